// File: rtl/uart_pkg.sv
// Shared UART constants: parity-mode encodings and the transmitter state type.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// (bit_end_o) and second-to-last (bit_pre_o) clock of every bit.
module uart_baud_gen #(
   parameter int BAUD_DIV = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic bit_end_o,
   output logic bit_pre_o
);

   localparam int            CW   = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(BAUD_DIV - 2);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign bit_end_o = en_i && (cnt_q == LAST);
   assign bit_pre_o = en_i && (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_param.sv
// FIFO-fed UART transmitter: fetches one word per frame and serialises
// start, DATA_BITS data (LSB first), optional parity and STOP_BITS stop bits.
module uart_tx_param #(
   parameter int BAUD_DIV  = 5208,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       rs232_tx,
   output logic       rfifo_rd_en,
   input  logic [7:0] rfifo_rd_data,
   input  logic       rfifo_empty,
   output logic       tx_busy,
   output logic       frame_done
);

   import uart_pkg::*;

   if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud
      $error("uart_tx_param: BAUD_DIV must be in 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be in 5..8");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   localparam int            BW        = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_e              state_q;
   logic                   tx_q;
   logic                   rd_en_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   par_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [BW-1:0]          bit_cnt_q;

   logic baud_en;
   logic baud_clr;
   logic bit_end;
   logic bit_pre;
   logic last_stop;
   logic unused_rd_bits;

   assign baud_en   = (state_q == START) || (state_q == DATA) ||
                      (state_q == PAR)   || (state_q == STOP);
   assign baud_clr  = (state_q == LOAD);
   assign last_stop = (bit_cnt_q == LAST_STOP);
   assign unused_rd_bits = ^rfifo_rd_data;

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .en_i      (baud_en),
      .clr_i     (baud_clr),
      .bit_end_o (bit_end),
      .bit_pre_o (bit_pre)
   );

   // Every output is loaded one clock ahead so the pins come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         par_q     <= 1'b0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rfifo_empty) begin
                  state_q <= READ;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            READ: state_q <= LOAD;
            LOAD: begin
               shift_q   <= rfifo_rd_data[DATA_BITS-1:0];
               par_q     <= (PARITY == PAR_ODD) ? ~^rfifo_rd_data[DATA_BITS-1:0]
                                                :  ^rfifo_rd_data[DATA_BITS-1:0];
               tx_q      <= 1'b0;
               bit_cnt_q <= '0;
               state_q   <= START;
            end
            START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt_q == LAST_DATA) begin
                     bit_cnt_q <= '0;
                     if (PARITY != PAR_NONE) begin
                        tx_q    <= par_q;
                        state_q <= PAR;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end
            PAR: begin
               if (bit_end) begin
                  tx_q      <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= STOP;
               end
            end
            STOP: begin
               if (last_stop && bit_pre) begin
                  done_q <= 1'b1;
               end
               if (bit_end) begin
                  if (last_stop) begin
                     bit_cnt_q <= '0;
                     busy_q    <= 1'b0;
                     state_q   <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rs232_tx    = tx_q;
   assign rfifo_rd_en = rd_en_q;
   assign tx_busy     = busy_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five parameter sets run side by side against a
// per-cycle timeline model plus hand-computed frame expectations.
module tb_uart_tx_param;

   import uart_pkg::*;

   localparam int NC = 5;

   function automatic int cfg_bd(input int i);
      return (i == 4) ? 3 : 16;
   endfunction
   function automatic int cfg_db(input int i);
      case (i)
         0:       return 8;
         1, 2:    return 7;
         3:       return 5;
         default: return 6;
      endcase
   endfunction
   function automatic int cfg_par(input int i);
      case (i)
         1:       return 1;
         2, 4:    return 2;
         default: return 0;
      endcase
   endfunction
   function automatic int cfg_sb(input int i);
      return (i >= 3) ? 2 : 1;
   endfunction
   function automatic logic [7:0] cfg_byte(input int i);
      case (i)
         0:       return 8'hA5;
         1, 2:    return 8'h83;
         3:       return 8'h1F;
         default: return 8'hC6;
      endcase
   endfunction
   // Transmitted line levels, bit n of the vector = n-th bit on the wire.
   function automatic logic [11:0] cfg_lit(input int i);
      case (i)
         0:       return 12'h34A;
         1:       return 12'h206;
         2:       return 12'h306;
         3:       return 12'h0FE;
         default: return 12'h38C;
      endcase
   endfunction
   function automatic int cfg_len(input int i);
      case (i)
         3:       return 128;
         4:       return 30;
         default: return 160;
      endcase
   endfunction

   logic          clk;
   logic          rst;
   logic          rst_req;
   logic          force_empty;
   logic [NC-1:0] tx_w;
   logic [NC-1:0] rd_w;
   logic [NC-1:0] busy_w;
   logic [NC-1:0] done_w;
   logic [NC-1:0] empty_r;
   logic [NC-1:0] rd_last;
   logic [7:0]    rdd_r [NC];
   logic [7:0]    fifo_q [NC][$];
   logic [3:0]    exp_q [NC][$];
   int unsigned   n_tests = 0;
   int unsigned   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      uart_tx_param #(
         .BAUD_DIV  (cfg_bd(g)),
         .DATA_BITS (cfg_db(g)),
         .PARITY    (cfg_par(g)),
         .STOP_BITS (cfg_sb(g))
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .rs232_tx      (tx_w[g]),
         .rfifo_rd_en   (rd_w[g]),
         .rfifo_rd_data (rdd_r[g]),
         .rfifo_empty   (empty_r[g]),
         .tx_busy       (busy_w[g]),
         .frame_done    (done_w[g])
      );
   end

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cfg%0d @%0t: got %0h, want %0h", name, i, $time, act, expv);
      end
   endtask

   // Expected {tx, rd_en, busy, done} for every cycle from READ to the last stop clock.
   task automatic push_frame(input int i, input logic [7:0] b);
      logic bits[$];
      logic p;
      int   bd;
      int   last;
      bd = cfg_bd(i);
      p  = 1'b0;
      bits.push_back(1'b0);
      for (int k = 0; k < cfg_db(i); k++) begin
         bits.push_back(b[k]);
         p ^= b[k];
      end
      if (cfg_par(i) == PAR_EVEN) bits.push_back(p);
      else if (cfg_par(i) == PAR_ODD) bits.push_back(~p);
      for (int k = 0; k < cfg_sb(i); k++) bits.push_back(1'b1);
      exp_q[i].push_back(4'b1110);
      exp_q[i].push_back(4'b1010);
      last = bits.size() - 1;
      for (int n = 0; n <= last; n++)
         for (int j = 0; j < bd; j++)
            exp_q[i].push_back({bits[n], 1'b0, 1'b1, (n == last && j == bd - 1)});
   endtask

   task automatic tick();
      logic [3:0] e;
      logic       idle;
      @(posedge clk);
      #1;
      rst = rst_req;
      for (int i = 0; i < NC; i++) begin
         if (rd_last[i] && fifo_q[i].size() > 0) rdd_r[i] = fifo_q[i].pop_front();
         else rdd_r[i] = 8'($urandom);
         empty_r[i] = force_empty || (fifo_q[i].size() == 0);
      end
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         if (rst) begin
            exp_q[i].delete();
            e    = 4'b1000;
            idle = 1'b0;
         end else if (exp_q[i].size() == 0) begin
            e    = 4'b1000;
            idle = 1'b1;
         end else begin
            e    = exp_q[i].pop_front();
            idle = 1'b0;
         end
         chk("model", i, 32'({tx_w[i], rd_w[i], busy_w[i], done_w[i]}), 32'(e));
         rd_last[i] = rd_w[i];
         if (idle && !empty_r[i]) push_frame(i, fifo_q[i][0]);
      end
   endtask

   function automatic logic all_idle();
      for (int i = 0; i < NC; i++)
         if (exp_q[i].size() != 0 || fifo_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input int limit);
      for (int k = 0; k < limit && !all_idle(); k++) tick();
      chk("drain_timeout", 0, 32'(all_idle()), 32'd1);
   endtask

   initial begin : main
      int          first_rd [NC];
      int          done_at  [NC];
      int          done_cnt [NC];
      int          rd_cnt   [NC];
      int          low_cnt  [NC];
      logic [11:0] got      [NC];
      logic        pre_hi   [NC];
      logic        start_lo [NC];
      int          rel;
      int          lat;

      rst         = 1'b1;
      rst_req     = 1'b1;
      force_empty = 1'b0;
      empty_r     = '1;
      rd_last     = '0;
      for (int i = 0; i < NC; i++) rdd_r[i] = '0;
      repeat (3) tick();
      rst_req = 1'b0;
      repeat (3) tick();

      // Single known word per configuration, checked against literal frames.
      for (int i = 0; i < NC; i++) begin
         first_rd[i] = -1; done_at[i] = -1; done_cnt[i] = 0;
         got[i] = '0; pre_hi[i] = 1'b0; start_lo[i] = 1'b0;
         fifo_q[i].push_back(cfg_byte(i));
      end
      for (int k = 0; k < 200; k++) begin
         tick();
         for (int i = 0; i < NC; i++) begin
            if (first_rd[i] < 0 && rd_w[i]) first_rd[i] = k;
            if (first_rd[i] >= 0) begin
               rel = k - first_rd[i] - 2;
               if (rel == -1) pre_hi[i] = tx_w[i];
               if (rel == 0) start_lo[i] = ~tx_w[i];
               if (rel >= 0 && rel < cfg_len(i) && (rel % cfg_bd(i)) == cfg_bd(i) / 2)
                  got[i][rel / cfg_bd(i)] = tx_w[i];
               if (done_w[i]) begin
                  done_cnt[i]++;
                  done_at[i] = rel;
               end
            end
         end
      end
      for (int i = 0; i < NC; i++) begin
         chk("lit_bits", i, 32'(got[i]), 32'(cfg_lit(i)));
         chk("lit_start", i, 32'({pre_hi[i], start_lo[i]}), 32'd3);
         chk("lit_done_at", i, 32'(done_at[i]), 32'(cfg_len(i) - 1));
         chk("lit_done_cnt", i, 32'(done_cnt[i]), 32'd1);
      end

      // Back-to-back: three preloaded words, one idle-low busy cycle per gap.
      for (int i = 0; i < NC; i++) begin
         rd_cnt[i] = 0; done_cnt[i] = 0; low_cnt[i] = 0;
         fifo_q[i].push_back(8'h55);
         fifo_q[i].push_back(8'hAA);
         fifo_q[i].push_back(8'h0F);
      end
      for (int k = 0; k < 700 && !all_idle(); k++) begin
         tick();
         for (int i = 0; i < NC; i++) begin
            if (rd_cnt[i] >= 1 && done_cnt[i] < 3 && !busy_w[i]) low_cnt[i]++;
            if (rd_w[i]) rd_cnt[i]++;
            if (done_w[i]) done_cnt[i]++;
         end
      end
      for (int i = 0; i < NC; i++) begin
         chk("b2b_rd_pulses", i, 32'(rd_cnt[i]), 32'd3);
         chk("b2b_frames", i, 32'(done_cnt[i]), 32'd3);
         chk("b2b_busy_gaps", i, 32'(low_cnt[i]), 32'd2);
      end

      // Random traffic with the empty flag toggling underneath running frames.
      for (int k = 0; k < 3000; k++) begin
         tick();
         for (int i = 0; i < NC; i++)
            if (fifo_q[i].size() < 3 && $urandom_range(11, 0) == 0)
               fifo_q[i].push_back(8'($urandom));
         force_empty = ($urandom_range(4, 0) == 0);
      end
      force_empty = 1'b0;
      drain(2000);

      // Empty guard: words waiting but the flag held high.
      force_empty = 1'b1;
      for (int i = 0; i < NC; i++) begin
         rd_cnt[i] = 0; low_cnt[i] = 0;
         for (int n = 0; n < 3; n++) fifo_q[i].push_back(8'($urandom));
      end
      for (int k = 0; k < 1000; k++) begin
         tick();
         for (int i = 0; i < NC; i++) begin
            if (rd_w[i]) rd_cnt[i]++;
            if (!tx_w[i]) low_cnt[i]++;
         end
      end
      for (int i = 0; i < NC; i++) begin
         chk("guard_rd_en", i, 32'(rd_cnt[i]), 32'd0);
         chk("guard_tx_low", i, 32'(low_cnt[i]), 32'd0);
      end

      // Reset at clock 70 of a frame on the first configuration.
      force_empty = 1'b0;
      done_cnt[0] = 0;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         tick();
         if (rd_w[0]) lat = k;
      end
      chk("rst_first_read", 0, 32'(lat >= 0), 32'd1);
      repeat (72) begin
         tick();
         if (done_w[0]) done_cnt[0]++;
      end
      rst_req = 1'b1;
      tick();
      chk("rst_tx", 0, 32'(tx_w[0]), 32'd1);
      chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
      if (done_w[0]) done_cnt[0]++;
      tick();
      rst_req = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         tick();
         if (done_w[0]) done_cnt[0]++;
         if (rd_w[0]) lat = k;
      end
      chk("rst_no_done", 0, 32'(done_cnt[0]), 32'd0);
      chk("rst_restart_lat", 0, 32'(lat), 32'd2);
      drain(2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
